// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
// Holds the arbiter state enum, default widths and the burst-count width.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_LOAD  = 2'd1,
        S_YIELD = 2'd2
    } arb_state_t;

    localparam int ADDR_W_DEF         = 30;
    localparam int DATA_W_DEF         = 32;
    localparam int MEM_DEPTH_DEF      = 1024;
    localparam int LOAD_BURST_MAX_DEF = 4;

    // Width needed to hold a burst count of 0..max inclusive.
    function automatic int cnt_w(input int max);
        return $clog2(max + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_w(LOAD_BURST_MAX_DEF);

endpackage

// File: rtl/imem_arb_burst_ctr.sv
// Saturating count of consecutive loader grants.
// Ports: clk, reset (async high), clr, inc -> cnt, at_max.
// clr together with inc starts a new burst at 1.
module imem_arb_burst_ctr
    import imem_arb_pkg::*;
#(
    parameter int MAX = LOAD_BURST_MAX_DEF,
    parameter int W   = cnt_w(MAX)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    assign at_max = (cnt == W'(MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr && inc) begin
            cnt <= W'(1);
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single sync-read instruction memory between fetch
// (reads) and the program loader (writes), one access per cycle.
// Ports: fetch_req/addr -> fetch_gnt/valid/data, stall;
//        load_req/addr/data -> load_gnt;
//        mem_en/we/addr/wdata, mem_rdata; addr_err.
// Loader bursts are cut after LOAD_BURST_MAX grants when fetch waits.
// Optional macro IMEM_ARB_ADDR_CHECK_EN: out-of-range addresses are
// flagged on addr_err instead of wrapping into the memory.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int MEM_DEPTH      = MEM_DEPTH_DEF,
    parameter int LOAD_BURST_MAX = LOAD_BURST_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              addr_err
);

    localparam int CNT_W = cnt_w(LOAD_BURST_MAX);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             clr;
    logic             inc;
    logic             at_max;
    logic [CNT_W-1:0] cnt;
    logic             l_oor;
    logic [ADDR_W-1:0] f_map;
    logic [ADDR_W-1:0] l_map;

    imem_arb_burst_ctr #(
        .MAX (LOAD_BURST_MAX),
        .W   (CNT_W)
    ) u_ctr (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .inc    (inc),
        .cnt    (cnt),
        .at_max (at_max)
    );

`ifdef IMEM_ARB_ADDR_CHECK_EN
    logic f_oor;
    logic f_oor_q;

    assign f_oor = (fetch_addr >= ADDR_W'(MEM_DEPTH));
    assign l_oor = (load_addr >= ADDR_W'(MEM_DEPTH));
    assign f_map = fetch_addr;
    assign l_map = load_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_oor_q <= 1'b0;
        end else begin
            f_oor_q <= fetch_gnt && f_oor;
        end
    end

    assign fetch_data = (fetch_valid && !f_oor_q) ? mem_rdata : '0;
    assign addr_err   = (load_gnt && l_oor) || (fetch_valid && f_oor_q);
`else
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] IDX_MASK =
        ADDR_W'((64'd1 << IDX_W) - 64'd1);

    // Without the check, addresses wrap into the memory.
    assign l_oor = 1'b0;
    assign f_map = fetch_addr & IDX_MASK;
    assign l_map = load_addr & IDX_MASK;

    assign fetch_data = fetch_valid ? mem_rdata : '0;
    assign addr_err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Grants are gated by reset so every output drops immediately.
    always_comb begin
        state_nxt = state;
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        clr       = 1'b0;
        inc       = 1'b0;
        if (!reset) begin
            unique case (state)
                S_LOAD: begin
                    if (load_req && (!at_max || !fetch_req)) begin
                        load_gnt = 1'b1;
                        inc      = 1'b1;
                    end else if (load_req) begin
                        fetch_gnt = 1'b1;
                        clr       = 1'b1;
                        state_nxt = S_YIELD;
                    end else begin
                        fetch_gnt = fetch_req;
                        clr       = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end
                default: begin
                    if (load_req) begin
                        load_gnt  = 1'b1;
                        clr       = 1'b1;
                        inc       = 1'b1;
                        state_nxt = S_LOAD;
                    end else begin
                        fetch_gnt = fetch_req;
                        clr       = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end
            endcase
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (load_gnt) begin
            mem_en    = !l_oor;
            mem_we    = !l_oor;
            mem_addr  = l_map;
            mem_wdata = load_data;
        end else if (fetch_gnt) begin
            mem_en   = 1'b1;
            mem_addr = f_map;
        end
    end

    assign stall = fetch_req && !fetch_gnt && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_valid <= 1'b0;
        end else begin
            fetch_valid <= fetch_gnt;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: vector table, corner
// sequences and random traffic against a grant/memory model.
module tb_imem_arbiter;

    localparam int AW    = 30;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int BMAX  = 4;
`ifdef IMEM_ARB_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_gnt;
    logic          fetch_valid;
    logic [DW-1:0] fetch_data;
    logic          load_req;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          load_gnt;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall;
    logic          addr_err;

    always #5 clk = ~clk;

    imem_arbiter #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .MEM_DEPTH      (DEPTH),
        .LOAD_BURST_MAX (BMAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_gnt   (fetch_gnt),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .load_req    (load_req),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_gnt    (load_gnt),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .stall       (stall),
        .addr_err    (addr_err)
    );

    // Synchronous-read memory with a bench-side preload port.
    logic [DW-1:0] mem [0:DEPTH-1];
    logic          pre_we = 1'b0;
    logic [9:0]    pre_a  = '0;
    logic [DW-1:0] pre_d  = '0;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_a] <= pre_d;
        end else if (mem_en && mem_we) begin
            mem[mem_addr[9:0]] <= mem_wdata;
        end
        if (mem_en && !mem_we) begin
            mem_rdata <= mem[mem_addr[9:0]];
        end
    end

    int nchk = 0;
    int nerr = 0;

    // Reference model: grants from the burst rule, memory as an array.
    int            run;
    bit            m_fv;
    bit            m_ferr;
    logic [DW-1:0] m_fd;
    logic [DW-1:0] shadow [0:DEPTH-1];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic bit oor(input logic [AW-1:0] a);
        return CHECK_EN && (a >= AW'(DEPTH));
    endfunction

    function automatic logic [AW-1:0] xmap(input logic [AW-1:0] a);
        return CHECK_EN ? a : AW'(a % DEPTH);
    endfunction

    task automatic model_reset();
        run  = 0;
        m_fv = 1'b0;
        m_ferr = 1'b0;
        m_fd = '0;
    endtask

    task automatic cyc(input bit fr, input logic [AW-1:0] fa,
                       input bit lr, input logic [AW-1:0] la,
                       input logic [DW-1:0] ld);
        bit            e_fg;
        bit            e_lg;
        logic [AW-1:0] e_a;
        @(negedge clk);
        fetch_req  = fr;
        fetch_addr = fa;
        load_req   = lr;
        load_addr  = la;
        load_data  = ld;
        #1;
        e_fg = 1'b0;
        e_lg = 1'b0;
        if (lr) begin
            if (run >= BMAX && fr) e_fg = 1'b1;
            else e_lg = 1'b1;
        end else begin
            e_fg = fr;
        end
        e_a = e_lg ? xmap(la) : (e_fg ? xmap(fa) : '0);
        chk("fetch_gnt", fetch_gnt, e_fg);
        chk("load_gnt", load_gnt, e_lg);
        chk("stall", stall, fr && !e_fg);
        chk("mem_we", mem_we, e_lg && !oor(la));
        chk("mem_en", mem_en, (e_lg && !oor(la)) || e_fg);
        chk("mem_addr", mem_addr, e_a);
        chk("mem_wdata", mem_wdata, e_lg ? ld : '0);
        chk("fetch_valid", fetch_valid, m_fv);
        if (m_fv) chk("fetch_data", fetch_data, m_fd);
        chk("addr_err", addr_err, (e_lg && oor(la)) || (m_fv && m_ferr));
        if (e_lg) begin
            run = (run < BMAX) ? run + 1 : BMAX;
            if (!oor(la)) shadow[int'(la % DEPTH)] = ld;
        end else begin
            run = 0;
        end
        m_fv   = e_fg;
        m_ferr = e_fg && oor(fa);
        m_fd   = m_ferr ? '0 : shadow[int'(fa % DEPTH)];
    endtask

    task automatic idle_inputs();
        fetch_req  = 1'b0;
        fetch_addr = '0;
        load_req   = 1'b0;
        load_addr  = '0;
        load_data  = '0;
    endtask

    task automatic chk_all_zero(input string n);
        chk({n, "_fgnt"}, fetch_gnt, 0);
        chk({n, "_lgnt"}, load_gnt, 0);
        chk({n, "_fvalid"}, fetch_valid, 0);
        chk({n, "_fdata"}, fetch_data, 0);
        chk({n, "_stall"}, stall, 0);
        chk({n, "_mem_en"}, mem_en, 0);
        chk({n, "_mem_we"}, mem_we, 0);
        chk({n, "_mem_addr"}, mem_addr, 0);
        chk({n, "_mem_wdata"}, mem_wdata, 0);
        chk({n, "_addr_err"}, addr_err, 0);
    endtask

    typedef struct {
        bit            fr;
        logic [AW-1:0] fa;
        bit            lr;
        logic [AW-1:0] la;
        logic [DW-1:0] ld;
        bit            fg;
        bit            lg;
        bit            st;
        bit            fv;
        logic [DW-1:0] fd;
    } vec_t;

    function automatic vec_t mk(bit fr, int fa, bit lr, int la,
                                logic [DW-1:0] ld, bit fg, bit lg,
                                bit st, bit fv, logic [DW-1:0] fd);
        vec_t v;
        v.fr = fr; v.fa = AW'(fa); v.lr = lr; v.la = AW'(la);
        v.ld = ld; v.fg = fg; v.lg = lg; v.st = st;
        v.fv = fv; v.fd = fd;
        return v;
    endfunction

    vec_t vt [18];

    initial begin
        // Fetch-only stream, preloaded A0.. at 0..
        vt[0]  = mk(1, 0, 0, 0, 0,    1, 0, 0, 0, 0);
        vt[1]  = mk(1, 1, 0, 0, 0,    1, 0, 0, 1, 32'hA0);
        vt[2]  = mk(1, 2, 0, 0, 0,    1, 0, 0, 1, 32'hA1);
        vt[3]  = mk(0, 0, 0, 0, 0,    0, 0, 0, 1, 32'hA2);
        // Both requesting: L,L,L,L,F,L,L,L,L,F
        vt[4]  = mk(1, 3, 1, 8, 'h55, 0, 1, 1, 0, 0);
        vt[5]  = mk(1, 3, 1, 8, 'h55, 0, 1, 1, 0, 0);
        vt[6]  = mk(1, 3, 1, 8, 'h55, 0, 1, 1, 0, 0);
        vt[7]  = mk(1, 3, 1, 8, 'h55, 0, 1, 1, 0, 0);
        vt[8]  = mk(1, 3, 1, 8, 'h55, 1, 0, 0, 0, 0);
        vt[9]  = mk(1, 3, 1, 8, 'h55, 0, 1, 1, 1, 32'hA3);
        vt[10] = mk(1, 3, 1, 8, 'h55, 0, 1, 1, 0, 0);
        vt[11] = mk(1, 3, 1, 8, 'h55, 0, 1, 1, 0, 0);
        vt[12] = mk(1, 3, 1, 8, 'h55, 0, 1, 1, 0, 0);
        vt[13] = mk(1, 3, 1, 8, 'h55, 1, 0, 0, 0, 0);
        vt[14] = mk(0, 0, 0, 0, 0,    0, 0, 0, 1, 32'hA3);
        // Read-after-write
        vt[15] = mk(0, 0, 1, 5, 32'hDEADBEEF, 0, 1, 0, 0, 0);
        vt[16] = mk(1, 5, 0, 0, 0,    1, 0, 0, 0, 0);
        vt[17] = mk(0, 0, 0, 0, 0,    0, 0, 0, 1, 32'hDEADBEEF);

        // Reset state, with requests active.
        reset      = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = AW'(7);
        load_req   = 1'b1;
        load_addr  = AW'(9);
        load_data  = 32'h1234;
        #2;
        chk_all_zero("reset");
        idle_inputs();
        model_reset();

        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            pre_we = 1'b1;
            pre_a  = (i < 32) ? 10'(i) : 10'd976;
            pre_d  = 32'hA0 + 32'(i);
            shadow[int'(pre_a)] = pre_d;
        end
        @(negedge clk);
        pre_we = 1'b0;
        reset  = 1'b0;

        for (int i = 0; i < 18; i++) begin
            cyc(vt[i].fr, vt[i].fa, vt[i].lr, vt[i].la, vt[i].ld);
            chk($sformatf("vec%0d_fgnt", i), fetch_gnt, vt[i].fg);
            chk($sformatf("vec%0d_lgnt", i), load_gnt, vt[i].lg);
            chk($sformatf("vec%0d_stall", i), stall, vt[i].st);
            chk($sformatf("vec%0d_fvalid", i), fetch_valid, vt[i].fv);
            if (vt[i].fv)
                chk($sformatf("vec%0d_fdata", i), fetch_data, vt[i].fd);
        end

        // Burst counter saturates while fetch is idle.
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, AW'(9), 32'h99);
        cyc(1, AW'(4), 1, AW'(9), 32'h99);
        chk("sat_fetch_gnt", fetch_gnt, 1);
        chk("sat_load_gnt", load_gnt, 0);
        cyc(0, 0, 0, 0, 0);
        chk("sat_fetch_data", fetch_data, 32'hA4);

        // Reset during the second load grant of a burst.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, AW'(10), 32'h1010);
        @(negedge clk);
        fetch_req  = 1'b1;
        fetch_addr = '0;
        load_req   = 1'b1;
        load_addr  = AW'(11);
        load_data  = 32'h1111;
        #1;
        chk("pre_rst_load_gnt", load_gnt, 1);
        reset = 1'b1;
        #1;
        chk_all_zero("midburst");
        model_reset();
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        cyc(1, AW'(10), 0, 0, 0);
        chk("rst_first_fgnt", fetch_gnt, 1);
        cyc(1, AW'(11), 0, 0, 0);
        chk("rst_l1_written", fetch_data, 32'h1010);
        cyc(0, 0, 0, 0, 0);
        chk("rst_l2_dropped", fetch_data, 32'hAB);

        // Reset discards an outstanding read.
        cyc(1, AW'(2), 0, 0, 0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("rd_out_valid", fetch_valid, 1);
        reset = 1'b1;
        #1;
        chk("rd_out_killed", fetch_valid, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

`ifdef IMEM_ARB_ADDR_CHECK_EN
        cyc(1, AW'(1024), 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("oor_fetch_data", fetch_data, 0);
        chk("oor_fetch_err", addr_err, 1);
        cyc(0, 0, 1, AW'(2000), 32'h77);
        chk("oor_load_we", mem_we, 0);
        chk("oor_load_err", addr_err, 1);
        cyc(1, AW'(976), 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("oor_mem_unchanged", fetch_data, 32'hA0 + 32'd32);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, AW'($urandom_range(0, 31)),
                $urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)),
                $urandom);
        end
        cyc(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 nchk, nerr);
        $finish;
    end

endmodule
